// File: rtl/wb_fec_pkg.sv
// Shared types and constants for the FEC fabric wrapper: fabric record,
// control-register map, ID constant and frame-buffer FSM states.
package wb_fec_pkg;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [1:0]  sel;
        logic [1:0]  adr;
        logic [15:0] dat;
        logic        stall;
        logic        ack;
    } t_wb_fabric;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX,
        ST_TX1,
        ST_TX2
    } t_fec_state;

    // Control-slave word indices (byte address bits [4:2])
    localparam logic [2:0] c_reg_enc_en   = 3'd0;
    localparam logic [2:0] c_reg_dec_en   = 3'd1;
    localparam logic [2:0] c_reg_rx_cnt   = 3'd2;
    localparam logic [2:0] c_reg_tx_cnt   = 3'd3;
    localparam logic [2:0] c_reg_drop_cnt = 3'd4;
    localparam logic [2:0] c_reg_clr      = 3'd5;
    localparam logic [2:0] c_reg_id       = 3'd6;

    localparam logic [27:0] c_id_magic    = 28'hFEC0000;
    localparam logic [6:0]  c_ack_timeout = 7'd64;

    function automatic logic [1:0] pulse_sum(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/wb_fec_frame_buf.sv
// Single-frame store-and-forward buffer for a 16-bit pipelined Wishbone fabric;
// replays the stored frame once, or twice when rep2 is sampled high at end of RX.
module wb_fec_frame_buf
    import wb_fec_pkg::*;
#(
    parameter int unsigned g_buf_words = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en,
    input  logic        rep2,
    input  logic        sink_cyc,
    input  logic        sink_stb,
    input  logic [1:0]  sink_sel,
    input  logic [1:0]  sink_adr,
    input  logic [15:0] sink_dat,
    output logic        sink_stall,
    output logic        sink_ack,
    output logic        src_cyc,
    output logic        src_stb,
    output logic        src_we,
    output logic [1:0]  src_sel,
    output logic [1:0]  src_adr,
    output logic [15:0] src_dat,
    input  logic        src_stall,
    input  logic        src_ack,
    output logic        rx_inc,
    output logic        tx_inc,
    output logic        drop_inc
);

    localparam int unsigned LW = $clog2(g_buf_words + 1);
    localparam int unsigned AW = $clog2(g_buf_words);
    localparam logic [LW-1:0] c_full = LW'(g_buf_words);
    localparam logic [LW-1:0] c_one  = LW'(1);

    t_fec_state    state_q, state_d;
    logic [LW-1:0] len_q, len_d, rd_q, rd_d, pend_q, pend_d;
    logic [6:0]    tmo_q, tmo_d;
    logic          drop_q, drop_d, rep2_q, rep2_d;
    logic          cyc_q, cyc_d, stb_q, stb_d, ack_q;
    logic          tx_state, accept, src_acc, ack_in, wr_en;
    logic [19:0]   mem [g_buf_words];
    logic [19:0]   rd_word;
    t_wb_fabric    src_rec;
    logic          unused_rec;

    assign tx_state   = (state_q == ST_TX1) || (state_q == ST_TX2);
    assign sink_stall = tx_state;
    assign accept     = sink_cyc & sink_stb & ~tx_state;
    assign sink_ack   = ack_q;
    assign src_acc    = cyc_q & stb_q & ~src_stall;
    assign ack_in     = cyc_q & src_ack;
    assign rd_word    = mem[rd_q[AW-1:0]];

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_d     = rd_q;
        tmo_d    = tmo_q;
        drop_d   = drop_q;
        rep2_d   = rep2_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        wr_en    = 1'b0;
        rx_inc   = 1'b0;
        tx_inc   = 1'b0;
        drop_inc = 1'b0;

        pend_d = pend_q;
        if (src_acc && !ack_in)
            pend_d = pend_q + c_one;
        else if (!src_acc && ack_in && pend_q != '0)
            pend_d = pend_q - c_one;

        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                // Disabled path stays here: words are still accepted and acked, never stored
                if (en && sink_cyc) begin
                    state_d = ST_RX;
                    if (accept) begin
                        wr_en = 1'b1;
                        len_d = c_one;
                    end
                end
            end
            ST_RX: begin
                if (accept) begin
                    if (len_q == c_full) begin
                        drop_d   = 1'b1;
                        drop_inc = ~drop_q;
                    end else if (!drop_q) begin
                        wr_en = 1'b1;
                        len_d = len_q + c_one;
                    end
                end
                if (!sink_cyc) begin
                    if (drop_q || len_q == '0) begin
                        state_d = ST_IDLE;
                        len_d   = '0;
                    end else begin
                        state_d = ST_TX1;
                        rx_inc  = 1'b1;
                        rep2_d  = rep2;
                    end
                end
            end
            ST_TX1, ST_TX2: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    rd_d  = '0;
                    tmo_d = '0;
                end else if (stb_q) begin
                    if (src_acc) begin
                        rd_d = rd_q + c_one;
                        if (rd_q == len_q - c_one)
                            stb_d = 1'b0;
                    end
                end else if (pend_d == '0 || tmo_q == c_ack_timeout) begin
                    cyc_d  = 1'b0;
                    pend_d = '0;
                    tx_inc = 1'b1;
                    if (state_q == ST_TX1 && rep2_q) begin
                        state_d = ST_TX2;
                    end else begin
                        state_d = ST_IDLE;
                        len_d   = '0;
                    end
                end else begin
                    tmo_d = tmo_q + 7'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            rd_q    <= '0;
            pend_q  <= '0;
            tmo_q   <= '0;
            drop_q  <= 1'b0;
            rep2_q  <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rd_q    <= rd_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
            drop_q  <= drop_d;
            rep2_q  <= rep2_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            ack_q   <= accept;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[len_q[AW-1:0]] <= {sink_adr, sink_sel, sink_dat};
    end

    always_comb begin
        src_rec     = '0;
        src_rec.cyc = cyc_q;
        src_rec.stb = stb_q;
        src_rec.we  = cyc_q;
        if (stb_q) begin
            src_rec.adr = rd_word[19:18];
            src_rec.sel = rd_word[17:16];
            src_rec.dat = rd_word[15:0];
        end
    end

    assign src_cyc    = src_rec.cyc;
    assign src_stb    = src_rec.stb;
    assign src_we     = src_rec.we;
    assign src_sel    = src_rec.sel;
    assign src_adr    = src_rec.adr;
    assign src_dat    = src_rec.dat;
    assign unused_rec = src_rec.stall ^ src_rec.ack;

endmodule

// File: rtl/wb_fec_fabric_core.sv
// FEC fabric wrapper: repetition-coded encoder path, optional pass-through decoder
// path, and a 32-bit pipelined Wishbone control slave with enables and counters.
module wb_fec_fabric_core
    import wb_fec_pkg::*;
#(
    parameter int unsigned g_en_fec_enc  = 1,
    parameter int unsigned g_en_fec_dec  = 0,
    parameter int unsigned g_en_golay    = 0,
    parameter int unsigned g_en_dec_time = 0,
    parameter int unsigned g_buf_words   = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        fec_enc_sink_cyc,
    input  logic        fec_enc_sink_stb,
    input  logic        fec_enc_sink_we,
    input  logic [1:0]  fec_enc_sink_sel,
    input  logic [1:0]  fec_enc_sink_adr,
    input  logic [15:0] fec_enc_sink_dat,
    output logic        fec_enc_sink_stall,
    output logic        fec_enc_sink_ack,
    output logic        fec_enc_src_cyc,
    output logic        fec_enc_src_stb,
    output logic        fec_enc_src_we,
    output logic [1:0]  fec_enc_src_sel,
    output logic [1:0]  fec_enc_src_adr,
    output logic [15:0] fec_enc_src_dat,
    input  logic        fec_enc_src_stall,
    input  logic        fec_enc_src_ack,
    input  logic        fec_dec_sink_cyc,
    input  logic        fec_dec_sink_stb,
    input  logic        fec_dec_sink_we,
    input  logic [1:0]  fec_dec_sink_sel,
    input  logic [1:0]  fec_dec_sink_adr,
    input  logic [15:0] fec_dec_sink_dat,
    output logic        fec_dec_sink_stall,
    output logic        fec_dec_sink_ack,
    output logic        fec_dec_src_cyc,
    output logic        fec_dec_src_stb,
    output logic        fec_dec_src_we,
    output logic [1:0]  fec_dec_src_sel,
    output logic [1:0]  fec_dec_src_adr,
    output logic [15:0] fec_dec_src_dat,
    input  logic        fec_dec_src_stall,
    input  logic        fec_dec_src_ack,
    input  logic        wb_slave_cyc,
    input  logic        wb_slave_stb,
    input  logic        wb_slave_we,
    input  logic [3:0]  wb_slave_sel,
    input  logic [31:0] wb_slave_adr,
    input  logic [31:0] wb_slave_dat_i,
    output logic [31:0] wb_slave_dat_o,
    output logic        wb_slave_ack,
    output logic        wb_slave_stall
);

    logic        enc_en_q, dec_en_q, slv_ack_q;
    logic [31:0] rx_cnt_q, tx_cnt_q, drop_cnt_q, dat_q, rdata;
    logic        slv_acc, slv_wr, clr;
    logic [2:0]  slv_word;
    logic [3:0]  id_bits;
    logic        enc_rx, enc_tx, enc_drop, dec_rx, dec_tx, dec_drop;
    logic        unused_top;

    assign slv_acc  = wb_slave_cyc & wb_slave_stb;
    assign slv_word = wb_slave_adr[4:2];
    assign slv_wr   = slv_acc & wb_slave_we & wb_slave_sel[0];
    assign clr      = slv_wr & (slv_word == c_reg_clr) & wb_slave_dat_i[0];
    assign id_bits  = {g_en_dec_time != 0, g_en_golay != 0, g_en_fec_dec != 0, g_en_fec_enc != 0};

    always_comb begin
        rdata = '0;
        case (slv_word)
            c_reg_enc_en:   rdata = {31'd0, enc_en_q};
            c_reg_dec_en:   rdata = {31'd0, dec_en_q};
            c_reg_rx_cnt:   rdata = rx_cnt_q;
            c_reg_tx_cnt:   rdata = tx_cnt_q;
            c_reg_drop_cnt: rdata = drop_cnt_q;
            c_reg_id:       rdata = {c_id_magic, id_bits};
            default:        rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            enc_en_q   <= 1'b0;
            dec_en_q   <= 1'b0;
            slv_ack_q  <= 1'b0;
            dat_q      <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            slv_ack_q <= slv_acc;
            dat_q     <= (slv_acc && !wb_slave_we) ? rdata : '0;
            if (slv_wr && slv_word == c_reg_enc_en)
                enc_en_q <= wb_slave_dat_i[0];
            if (slv_wr && slv_word == c_reg_dec_en)
                dec_en_q <= wb_slave_dat_i[0];
            // Clear takes priority over a same-cycle increment
            if (clr) begin
                rx_cnt_q   <= '0;
                tx_cnt_q   <= '0;
                drop_cnt_q <= '0;
            end else begin
                rx_cnt_q   <= rx_cnt_q + 32'(pulse_sum(enc_rx, dec_rx));
                tx_cnt_q   <= tx_cnt_q + 32'(pulse_sum(enc_tx, dec_tx));
                drop_cnt_q <= drop_cnt_q + 32'(pulse_sum(enc_drop, dec_drop));
            end
        end
    end

    assign wb_slave_dat_o = dat_q;
    assign wb_slave_ack   = slv_ack_q;
    assign wb_slave_stall = 1'b0;

    generate
        if (g_en_fec_enc != 0) begin : g_enc
            wb_fec_frame_buf #(.g_buf_words(g_buf_words)) u_enc_buf (
                .clk_i(clk_i), .rst_n_i(rst_n_i), .en(1'b1), .rep2(enc_en_q),
                .sink_cyc(fec_enc_sink_cyc), .sink_stb(fec_enc_sink_stb),
                .sink_sel(fec_enc_sink_sel), .sink_adr(fec_enc_sink_adr), .sink_dat(fec_enc_sink_dat),
                .sink_stall(fec_enc_sink_stall), .sink_ack(fec_enc_sink_ack),
                .src_cyc(fec_enc_src_cyc), .src_stb(fec_enc_src_stb), .src_we(fec_enc_src_we),
                .src_sel(fec_enc_src_sel), .src_adr(fec_enc_src_adr), .src_dat(fec_enc_src_dat),
                .src_stall(fec_enc_src_stall), .src_ack(fec_enc_src_ack),
                .rx_inc(enc_rx), .tx_inc(enc_tx), .drop_inc(enc_drop)
            );
        end else begin : g_enc_off
            logic ack_q;
            logic unused_enc;
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) ack_q <= 1'b0;
                else          ack_q <= fec_enc_sink_cyc & fec_enc_sink_stb;
            end
            assign fec_enc_sink_ack   = ack_q;
            assign fec_enc_sink_stall = 1'b0;
            assign fec_enc_src_cyc    = 1'b0;
            assign fec_enc_src_stb    = 1'b0;
            assign fec_enc_src_we     = 1'b0;
            assign fec_enc_src_sel    = '0;
            assign fec_enc_src_adr    = '0;
            assign fec_enc_src_dat    = '0;
            assign enc_rx             = 1'b0;
            assign enc_tx             = 1'b0;
            assign enc_drop           = 1'b0;
            assign unused_enc = ^{fec_enc_sink_sel, fec_enc_sink_adr, fec_enc_sink_dat,
                                  fec_enc_src_stall, fec_enc_src_ack};
        end

        if (g_en_fec_dec != 0) begin : g_dec
            wb_fec_frame_buf #(.g_buf_words(g_buf_words)) u_dec_buf (
                .clk_i(clk_i), .rst_n_i(rst_n_i), .en(dec_en_q), .rep2(1'b0),
                .sink_cyc(fec_dec_sink_cyc), .sink_stb(fec_dec_sink_stb),
                .sink_sel(fec_dec_sink_sel), .sink_adr(fec_dec_sink_adr), .sink_dat(fec_dec_sink_dat),
                .sink_stall(fec_dec_sink_stall), .sink_ack(fec_dec_sink_ack),
                .src_cyc(fec_dec_src_cyc), .src_stb(fec_dec_src_stb), .src_we(fec_dec_src_we),
                .src_sel(fec_dec_src_sel), .src_adr(fec_dec_src_adr), .src_dat(fec_dec_src_dat),
                .src_stall(fec_dec_src_stall), .src_ack(fec_dec_src_ack),
                .rx_inc(dec_rx), .tx_inc(dec_tx), .drop_inc(dec_drop)
            );
        end else begin : g_dec_off
            logic ack_q;
            logic unused_dec;
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) ack_q <= 1'b0;
                else          ack_q <= fec_dec_sink_cyc & fec_dec_sink_stb;
            end
            assign fec_dec_sink_ack   = ack_q;
            assign fec_dec_sink_stall = 1'b0;
            assign fec_dec_src_cyc    = 1'b0;
            assign fec_dec_src_stb    = 1'b0;
            assign fec_dec_src_we     = 1'b0;
            assign fec_dec_src_sel    = '0;
            assign fec_dec_src_adr    = '0;
            assign fec_dec_src_dat    = '0;
            assign dec_rx             = 1'b0;
            assign dec_tx             = 1'b0;
            assign dec_drop           = 1'b0;
            assign unused_dec = ^{fec_dec_sink_sel, fec_dec_sink_adr, fec_dec_sink_dat,
                                  fec_dec_src_stall, fec_dec_src_ack, dec_en_q};
        end
    endgenerate

    assign unused_top = ^{fec_enc_sink_we, fec_dec_sink_we, wb_slave_adr[31:5], wb_slave_adr[1:0],
                          wb_slave_sel[3:1], wb_slave_dat_i[31:1]};

endmodule

// File: tb/tb_wb_fec_fabric_core.sv
// Directed bench for wb_fec_fabric_core: frame replay, repetition, stall, ack
// timeout, overflow drop, disabled decoder, register map and mid-frame reset.
module tb_wb_fec_fabric_core;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        enc_sink_cyc = 0, enc_sink_stb = 0, enc_sink_we = 0;
    logic [1:0]  enc_sink_sel = '0, enc_sink_adr = '0;
    logic [15:0] enc_sink_dat = '0;
    logic        enc_sink_stall, enc_sink_ack;
    logic        enc_src_cyc, enc_src_stb, enc_src_we;
    logic [1:0]  enc_src_sel, enc_src_adr;
    logic [15:0] enc_src_dat;
    logic        enc_src_stall = 0, enc_src_ack = 0;
    logic        dec_sink_cyc = 0, dec_sink_stb = 0, dec_sink_we = 0;
    logic [1:0]  dec_sink_sel = '0, dec_sink_adr = '0;
    logic [15:0] dec_sink_dat = '0;
    logic        dec_sink_stall, dec_sink_ack;
    logic        dec_src_cyc, dec_src_stb, dec_src_we;
    logic [1:0]  dec_src_sel, dec_src_adr;
    logic [15:0] dec_src_dat;
    logic        wb_cyc = 0, wb_stb = 0, wb_we = 0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_adr = '0, wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack, wb_stall;

    wb_fec_fabric_core #(.g_en_fec_enc(1), .g_en_fec_dec(0), .g_en_golay(0),
                         .g_en_dec_time(0), .g_buf_words(1024)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .fec_enc_sink_cyc(enc_sink_cyc), .fec_enc_sink_stb(enc_sink_stb), .fec_enc_sink_we(enc_sink_we),
        .fec_enc_sink_sel(enc_sink_sel), .fec_enc_sink_adr(enc_sink_adr), .fec_enc_sink_dat(enc_sink_dat),
        .fec_enc_sink_stall(enc_sink_stall), .fec_enc_sink_ack(enc_sink_ack),
        .fec_enc_src_cyc(enc_src_cyc), .fec_enc_src_stb(enc_src_stb), .fec_enc_src_we(enc_src_we),
        .fec_enc_src_sel(enc_src_sel), .fec_enc_src_adr(enc_src_adr), .fec_enc_src_dat(enc_src_dat),
        .fec_enc_src_stall(enc_src_stall), .fec_enc_src_ack(enc_src_ack),
        .fec_dec_sink_cyc(dec_sink_cyc), .fec_dec_sink_stb(dec_sink_stb), .fec_dec_sink_we(dec_sink_we),
        .fec_dec_sink_sel(dec_sink_sel), .fec_dec_sink_adr(dec_sink_adr), .fec_dec_sink_dat(dec_sink_dat),
        .fec_dec_sink_stall(dec_sink_stall), .fec_dec_sink_ack(dec_sink_ack),
        .fec_dec_src_cyc(dec_src_cyc), .fec_dec_src_stb(dec_src_stb), .fec_dec_src_we(dec_src_we),
        .fec_dec_src_sel(dec_src_sel), .fec_dec_src_adr(dec_src_adr), .fec_dec_src_dat(dec_src_dat),
        .fec_dec_src_stall(1'b0), .fec_dec_src_ack(1'b0),
        .wb_slave_cyc(wb_cyc), .wb_slave_stb(wb_stb), .wb_slave_we(wb_we), .wb_slave_sel(wb_sel),
        .wb_slave_adr(wb_adr), .wb_slave_dat_i(wb_dat_i), .wb_slave_dat_o(wb_dat_o),
        .wb_slave_ack(wb_ack), .wb_slave_stall(wb_stall)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    logic [19:0] out_q[$];
    int frame_lens[$];
    int cur_len = 0, cycle = 0, last_acc = 0, fall_cyc = 0;
    int sink_acks = 0, dec_acks = 0, stall_viol = 0;
    bit dec_cyc_seen = 0, rnd_stall = 0, no_ack = 0, prev_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [7:0] exp_byte(input int k, input int seed);
        if (k < 6)  return 8'hFF;
        if (k < 12) return 8'(k - 5);
        return 8'((k * 7 + seed) & 255);
    endfunction

    function automatic logic [19:0] exp_word(input int i, input int nw, input int seed);
        logic [1:0] a, s;
        a = (i == 0) ? 2'b01 : 2'b00;
        s = (i == nw - 1) ? 2'b10 : 2'b11;
        return {a, s, exp_byte(2 * i, seed), exp_byte(2 * i + 1, seed)};
    endfunction

    // Downstream model and monitor: sample at negedge, drive at posedge+2
    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            cycle++;
            acc = enc_src_cyc && enc_src_stb && !enc_src_stall;
            if (acc) begin
                out_q.push_back({enc_src_adr, enc_src_sel, enc_src_dat});
                cur_len++;
                last_acc = cycle;
            end
            if (prev_cyc && !enc_src_cyc) begin
                frame_lens.push_back(cur_len);
                cur_len  = 0;
                fall_cyc = cycle;
            end
            prev_cyc = enc_src_cyc;
            if (enc_src_cyc && !enc_sink_stall) stall_viol++;
            if (enc_sink_ack) sink_acks++;
            if (dec_sink_ack) dec_acks++;
            if (dec_src_cyc)  dec_cyc_seen = 1;
            @(posedge clk);
            #2;
            enc_src_ack   = acc && !no_ack;
            enc_src_stall = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic clear_mon();
        out_q.delete();
        frame_lens.delete();
        cur_len = 0;
    endtask

    task automatic send_frame(input bit dec, input int nw, input int seed);
        logic [19:0] w;
        bit acc;
        int budget;
        @(posedge clk); #2;
        if (dec) dec_sink_cyc = 1; else enc_sink_cyc = 1;
        for (int i = 0; i < nw; i++) begin
            w = exp_word(i, nw, seed);
            if (dec) begin
                dec_sink_stb = 1; dec_sink_adr = w[19:18]; dec_sink_sel = w[17:16]; dec_sink_dat = w[15:0];
            end else begin
                enc_sink_stb = 1; enc_sink_adr = w[19:18]; enc_sink_sel = w[17:16]; enc_sink_dat = w[15:0];
            end
            acc = 0;
            budget = 0;
            while (!acc && budget < 4000) begin
                @(negedge clk);
                acc = dec ? !dec_sink_stall : !enc_sink_stall;
                @(posedge clk); #2;
                budget++;
            end
            if (!acc) begin
                check("send_stuck", 0, 1);
                break;
            end
        end
        enc_sink_stb = 0; enc_sink_cyc = 0;
        dec_sink_stb = 0; dec_sink_cyc = 0;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int b = 0;
        while (frame_lens.size() < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        check(tag, frame_lens.size() >= n, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_frames(input string tag, input int nw, input int seed, input int copies);
        int bad = 0;
        check({tag, "_nframes"}, frame_lens.size(), copies);
        foreach (frame_lens[f]) check({tag, "_len"}, frame_lens[f], nw);
        check({tag, "_nwords"}, out_q.size(), nw * copies);
        foreach (out_q[k]) if (out_q[k] !== exp_word(k % nw, nw, seed)) bad++;
        check({tag, "_bad_words"}, bad, 0);
    endtask

    task automatic wb_access(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                             output logic [31:0] rdat);
        int budget = 0;
        @(posedge clk); #2;
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_i = wdat; wb_sel = 4'hF;
        @(posedge clk); #2;
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(negedge clk);
        while (!wb_ack && budget < 16) begin
            @(negedge clk);
            budget++;
        end
        rdat = wb_dat_o;
        if (!wb_ack) check("wb_ack_timeout", 0, 1);
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(1, adr, d, dummy);
    endtask

    task automatic wb_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_access(0, adr, 32'h0, r);
        check(tag, r, exp);
    endtask

    initial begin
        int base, b, gap;

        repeat (2) @(negedge clk);
        check("rst_src_cyc", enc_src_cyc, 0);
        check("rst_sink_ack", enc_sink_ack, 0);
        check("rst_sink_stall", enc_sink_stall, 0);
        check("rst_wb_ack", wb_ack, 0);
        check("rst_wb_dat", wb_dat_o, 0);
        @(posedge clk); #2;
        rst_n_i = 1;
        wb_chk("rst_enc_en", 32'h00, 0);
        wb_chk("rst_rx_cnt", 32'h08, 0);
        wb_chk("rst_tx_cnt", 32'h0C, 0);
        wb_chk("rst_drop_cnt", 32'h10, 0);

        // Single copy with ENC_EN=0, 132-byte frame
        clear_mon(); base = sink_acks;
        send_frame(0, 66, 3);
        wait_frames("t1_done", 1, 2000);
        check_frames("t1", 66, 3, 1);
        check("t1_sink_acks", sink_acks - base, 66);
        wb_chk("t1_rx_cnt", 32'h08, 1);
        wb_chk("t1_tx_cnt", 32'h0C, 1);

        // Two copies with ENC_EN=1, 1500-byte frame
        wb_wr(32'h00, 1);
        wb_chk("t2_enc_en", 32'h00, 1);
        clear_mon();
        send_frame(0, 750, 11);
        wait_frames("t2_done", 2, 6000);
        check_frames("t2", 750, 11, 2);
        wb_chk("t2_rx_cnt", 32'h08, 2);
        wb_chk("t2_tx_cnt", 32'h0C, 3);

        // Random downstream stall
        clear_mon(); rnd_stall = 1; stall_viol = 0;
        send_frame(0, 200, 29);
        wait_frames("t3_done", 2, 6000);
        rnd_stall = 0;
        check_frames("t3", 200, 29, 2);
        check("t3_stall_held", stall_viol, 0);
        wb_chk("t3_tx_cnt", 32'h0C, 5);

        // Missing downstream ack: cyc is forced low after the timeout
        wb_wr(32'h00, 0);
        clear_mon(); no_ack = 1;
        send_frame(0, 4, 5);
        wait_frames("tmo_done", 1, 1000);
        no_ack = 0;
        gap = fall_cyc - last_acc;
        check("tmo_gap_in_range", gap >= 64 && gap <= 70, 1);
        check_frames("tmo", 4, 5, 1);
        wb_chk("tmo_rx_cnt", 32'h08, 4);
        wb_chk("tmo_tx_cnt", 32'h0C, 6);

        // Overflow: g_buf_words+1 words are dropped but all acked
        clear_mon(); base = sink_acks;
        send_frame(0, 1025, 7);
        repeat (200) @(negedge clk);
        check("t4_no_frame", frame_lens.size(), 0);
        check("t4_no_src_cyc", enc_src_cyc, 0);
        check("t4_sink_acks", sink_acks - base, 1025);
        wb_chk("t4_drop_cnt", 32'h10, 1);
        wb_chk("t4_rx_cnt", 32'h08, 4);

        // Decoder not built: acks and discards
        base = dec_acks;
        send_frame(1, 10, 1);
        repeat (5) @(negedge clk);
        check("t5_dec_acks", dec_acks - base, 10);
        check("t5_dec_src_idle", dec_cyc_seen, 0);
        wb_chk("t5_id", 32'h18, 32'hFEC00001);
        wb_wr(32'h1C, 32'hFFFF_FFFF);
        wb_chk("t5_unmapped", 32'h1C, 0);
        wb_chk("t5_enc_en_kept", 32'h00, 0);

        wb_wr(32'h14, 1);
        wb_chk("clr_rx_cnt", 32'h08, 0);
        wb_chk("clr_tx_cnt", 32'h0C, 0);
        wb_chk("clr_drop_cnt", 32'h10, 0);

        // Reset asserted during the second copy
        wb_wr(32'h00, 1);
        clear_mon();
        send_frame(0, 40, 13);
        wait_frames("t6_tx1_done", 1, 2000);
        b = 0;
        while (!enc_src_cyc && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("t6_in_tx2", enc_src_cyc, 1);
        repeat (3) @(negedge clk);
        #1 rst_n_i = 0;
        #1;
        check("t6_async_cyc", enc_src_cyc, 0);
        check("t6_async_stall", enc_sink_stall, 0);
        repeat (3) @(posedge clk);
        #2 rst_n_i = 1;
        wb_chk("t6_enc_en", 32'h00, 0);
        wb_chk("t6_rx_cnt", 32'h08, 0);
        clear_mon();
        send_frame(0, 8, 17);
        wait_frames("t6_next_done", 1, 1000);
        check_frames("t6_next", 8, 17, 1);
        wb_chk("t6_tx_cnt", 32'h0C, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
